// File: rtl/alu_serial_ctrl_if.sv
// Handshake and data bundle for alu_serial_ctrl.
//   start, alu_ctrl, a, b : operation request from the requester
//   busy, done            : progress / one-cycle completion pulse
//   result, zero, overflow: outcome, held until the next accepted start
// master = requester side, slave = ALU controller side.
interface alu_serial_ctrl_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output start, alu_ctrl, a, b,
    input  busy, done, result, zero, overflow
  );

  modport slave (
    input  start, alu_ctrl, a, b,
    output busy, done, result, zero, overflow
  );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: one 1-bit ALU slice is reused once per bit,
// LSB first, to compute AND/OR/ADD/SUB/SLT/NOR over WIDTH-bit operands.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : alu_serial_ctrl_if slave (start/alu_ctrl/a/b in,
//           busy/done/result/zero/overflow out)
// Latency: start accepted at edge 0 -> done high after edge WIDTH+1,
// busy falls at edge WIDTH+2.

// 1-bit ALU slice: optional a/b inversion, full adder, op select.
//   op 00 AND, 01 OR, 10 SUM, 11 LESS
//   set      : raw sum bit (sign of the difference at the MSB)
//   overflow : carry-in XOR carry-out (meaningful at the MSB only)
module alu_slice (
  input  logic       a,
  input  logic       b,
  input  logic       c_in,
  input  logic       less,
  input  logic       a_invert,
  input  logic       b_invert,
  input  logic [1:0] op,
  output logic       result,
  output logic       c_out,
  output logic       set,
  output logic       overflow
);
  logic aa;
  logic bb;
  logic sum;

  always_comb begin
    aa       = a ^ a_invert;
    bb       = b ^ b_invert;
    sum      = aa ^ bb ^ c_in;
    c_out    = (aa & bb) | (aa & c_in) | (bb & c_in);
    set      = sum;
    overflow = c_in ^ c_out;
    case (op)
      2'b00:   result = aa & bb;
      2'b01:   result = aa | bb;
      2'b10:   result = sum;
      default: result = less;
    endcase
  end
endmodule

module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  alu_serial_ctrl_if.slave   bus
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       ctrl_q;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             overflow_q;
  logic             msb_set;
  logic             msb_ovf;

  logic             s_result;
  logic             s_cout;
  logic             s_set;
  logic             s_ovf;
  logic             is_slt;
  logic             is_addsub;
  logic             last_bit;
  logic [WIDTH-1:0] fix_result;

  alu_slice slice (
    .a        (a_q[idx]),
    .b        (b_q[idx]),
    .c_in     (carry),
    .less     (1'b0),
    .a_invert (ctrl_q[3]),
    .b_invert (ctrl_q[2]),
    .op       (ctrl_q[1:0]),
    .result   (s_result),
    .c_out    (s_cout),
    .set      (s_set),
    .overflow (s_ovf)
  );

  always_comb begin
    is_slt     = (ctrl_q == 4'b0111);
    is_addsub  = (ctrl_q == 4'b0010) || (ctrl_q == 4'b0110);
    last_bit   = (idx == LAST);
    // SLT: upper bits were written as 0 by less=0; bit 0 is the
    // overflow-corrected sign of a-b.
    fix_result = result_q;
    if (is_slt) begin
      fix_result[0] = msb_set ^ msb_ovf;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) begin
          state_next = CALC;
        end
      end
      CALC: begin
        if (last_bit) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      idx        <= '0;
      carry      <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      msb_set    <= 1'b0;
      msb_ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            ctrl_q     <= bus.alu_ctrl;
            idx        <= '0;
            carry      <= bus.alu_ctrl[2];
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
          end
        end
        CALC: begin
          result_q[idx] <= s_result;
          carry         <= s_cout;
          if (last_bit) begin
            msb_set <= s_set;
            msb_ovf <= s_ovf;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        FIX: begin
          result_q   <= fix_result;
          zero_q     <= (fix_result == '0);
          overflow_q <= is_addsub ? msb_ovf : 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl (WIDTH=32): directed operations
// with literal expectations plus a cycle-level arithmetic reference model.
module tb_alu_serial_ctrl;
  localparam int W = 32;

  logic clk;
  logic reset;
  int   nerr;
  int   nchecks;

  alu_serial_ctrl_if #(.WIDTH(W)) bus ();

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: returns {overflow, result} from plain arithmetic.
  function automatic logic [W:0] model(input logic [3:0] c, input logic [W-1:0] av,
                                       input logic [W-1:0] bv);
    logic [W-1:0] aa;
    logic [W-1:0] bb;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic         o;
    aa = c[3] ? ~av : av;
    bb = c[2] ? ~bv : bv;
    s  = aa + bb + W'(c[2]);
    o  = 1'b0;
    case (c[1:0])
      2'b00:   r = aa & bb;
      2'b01:   r = aa | bb;
      2'b10:   r = s;
      default: r = '0;
    endcase
    if (c == 4'b0111) begin
      r    = '0;
      r[0] = ($signed(av) < $signed(bv));
    end
    if (c == 4'b0010) o = (av[W-1] == bv[W-1]) && (s[W-1] != av[W-1]);
    if (c == 4'b0110) o = (av[W-1] != bv[W-1]) && (s[W-1] != av[W-1]);
    return {o, r};
  endfunction

  // Cycle-level expectation: accept when idle, done WIDTH+1 edges later,
  // idle again one edge after that.
  logic         m_busy;
  int           m_cnt;
  logic         m_valid;
  logic [W:0]   m_pend;
  logic [W-1:0] m_res;
  logic         m_zero;
  logic         m_ovf;
  logic         m_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy  <= 1'b0;
      m_cnt   <= 0;
      m_valid <= 1'b1;
      m_pend  <= '0;
      m_res   <= '0;
      m_zero  <= 1'b0;
      m_ovf   <= 1'b0;
    end else if (!m_busy) begin
      if (bus.start) begin
        m_busy  <= 1'b1;
        m_cnt   <= 0;
        m_valid <= 1'b0;
        m_pend  <= model(bus.alu_ctrl, bus.a, bus.b);
      end
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == W) begin
        m_res   <= m_pend[W-1:0];
        m_zero  <= (m_pend[W-1:0] == '0);
        m_ovf   <= m_pend[W];
        m_valid <= 1'b1;
      end
      if (m_cnt == W + 1) m_busy <= 1'b0;
    end
  end

  assign m_done = m_busy && (m_cnt == W + 1);

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", W'(bus.busy), W'(m_busy));
      chk("done", W'(bus.done), W'(m_done));
      if (m_valid) begin
        chk("model_result", bus.result, m_res);
        chk("model_zero", W'(bus.zero), W'(m_zero));
        chk("model_overflow", W'(bus.overflow), W'(m_ovf));
      end
    end
  end

  task automatic run_op(input string nm, input logic [3:0] c, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] er, input logic eo);
    int edges;
    bit seen;
    @(posedge clk);
    #2;
    bus.start = 1'b1; bus.alu_ctrl = c; bus.a = av; bus.b = bv;
    @(posedge clk);
    #2;
    bus.start = 1'b0; bus.a = ~av; bus.b = $urandom; bus.alu_ctrl = 4'b0001;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 100) begin
      @(posedge clk);
      edges++;
      #1;
      if (bus.done) seen = 1'b1;
    end
    chk({nm, "_latency"}, W'(edges), W'(W + 1));
    chk({nm, "_result"}, bus.result, er);
    chk({nm, "_overflow"}, W'(bus.overflow), W'(eo));
    chk({nm, "_zero"}, W'(bus.zero), W'(er == '0));
    @(posedge clk);
    #1;
    chk({nm, "_busy_fall"}, W'(bus.busy), '0);
  endtask

  initial begin
    int pulses;
    int d1;
    int d2;
    int edges;
    logic [W-1:0] r;
    nerr = 0;
    nchecks = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.alu_ctrl = '0; bus.a = '0; bus.b = '0;
    #3 reset = 1'b1;
    #1;
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_done", W'(bus.done), '0);
    chk("rst_result", bus.result, '0);
    chk("rst_zero", W'(bus.zero), '0);
    chk("rst_overflow", W'(bus.overflow), '0);
    #12 reset = 1'b0;

    run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
    run_op("sub_zero", 4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0);
    run_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
    run_op("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0);
    run_op("slt_ovfc", 4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0);
    run_op("nor", 4'b1100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("and", 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    run_op("or", 4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0);
    run_op("add_plain", 4'b0010, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0);
    run_op("undef_nand", 4'b1101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FFF_0FFF, 1'b0);
    run_op("undef_less", 4'b0011, 32'h0000_0003, 32'h0000_0009, 32'h0000_0000, 1'b0);

    // start pulsed while busy must be ignored
    @(posedge clk);
    #2;
    bus.start = 1'b1; bus.alu_ctrl = 4'b0010; bus.a = 32'd1; bus.b = 32'd2;
    @(posedge clk);
    #2 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    bus.start = 1'b1; bus.alu_ctrl = 4'b0110; bus.a = 32'd100; bus.b = 32'd200;
    @(posedge clk);
    #2 bus.start = 1'b0;
    pulses = 0;
    r = '0;
    for (int i = 0; i < W + 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        pulses++;
        r = bus.result;
      end
    end
    chk("ignore_pulses", W'(pulses), W'(1));
    chk("ignore_result", r, 32'd3);

    // reset during CALC bit 10 aborts without a done pulse
    @(posedge clk);
    #2;
    bus.start = 1'b1; bus.alu_ctrl = 4'b0010; bus.a = 32'h0000_1234; bus.b = 32'h0000_0001;
    @(posedge clk);
    #2 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_abort_partial", W'(bus.result != '0), W'(1));
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", W'(bus.busy), '0);
    chk("abort_done", W'(bus.done), '0);
    chk("abort_result", bus.result, '0);
    chk("abort_zero", W'(bus.zero), '0);
    chk("abort_overflow", W'(bus.overflow), '0);
    @(posedge clk);
    #2 reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    chk("abort_no_done", W'(pulses), '0);
    run_op("post_reset_add", 4'b0010, 32'd3, 32'd4, 32'd7, 1'b0);

    // start held high: back-to-back operations every WIDTH+3 cycles
    @(posedge clk);
    #2;
    bus.start = 1'b1; bus.alu_ctrl = 4'b0010; bus.a = 32'd10; bus.b = 32'd20;
    @(posedge clk);
    edges = 0; d1 = -1; d2 = -1;
    while (d2 < 0 && edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
      if (bus.done) begin
        if (d1 < 0) d1 = edges;
        else d2 = edges;
      end
    end
    bus.start = 1'b0;
    chk("b2b_first", W'(d1), W'(W + 1));
    chk("b2b_spacing", W'(d2 - d1), W'(W + 3));
    chk("b2b_result", bus.result, 32'd30);
    repeat (4) @(posedge clk);
    #1;
    chk("final_idle", W'(bus.busy), '0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (WIDTH >= 2).
REQ-002 SHALL have port clk  input  1  rising-edge system clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port alu_ctrl  input  4  operation code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking result/zero/overflow valid.
REQ-010 SHALL have port result  output  WIDTH  operation result, held until the next accepted start.
REQ-011 SHALL have port zero  output  1  high when result is all zeros.
REQ-012 SHALL have port overflow  output  1  signed overflow of ADD/SUB; 0 for all other ops.

Function
REQ-013 SHALL contain exactly one instance of the team's 1-bit ALU slice (a/b invert, full adder, op select AND/OR/SUM/LESS) and reuse it once per bit, LSB first.
REQ-014 SHALL decode alu_ctrl into Ainvert = alu_ctrl[3], Binvert = alu_ctrl[2], slice op = alu_ctrl[1:0].
REQ-015 SHALL implement states IDLE, CALC, FIX, DONE; reset state IDLE.
REQ-016 IDLE: on start=1 at a rising edge, SHALL latch a, b, alu_ctrl, clear bit index to 0, load carry register with Binvert, clear result, go to CALC.
REQ-017 CALC: each edge SHALL drive the slice with latched a[i], b[i], carry register as c_in, less=0; write slice result into result[i]; store slice c_out into carry register; increment i.
REQ-018 CALC: at i = WIDTH-1 SHALL additionally capture slice set and overflow as msb_set/msb_ovf and go to FIX.
REQ-019 FIX: for SLT SHALL write result[0] = msb_set XOR msb_ovf (upper bits already 0 via less=0); for ADD/SUB SHALL set overflow = msb_ovf; otherwise overflow = 0; SHALL compute zero from final result; go to DONE.
REQ-020 DONE: done SHALL be 1 for exactly this one cycle; next edge SHALL return to IDLE.
REQ-021 busy SHALL be 1 in CALC, FIX and DONE, 0 in IDLE.
REQ-022 Latency: with start accepted at edge 0, done SHALL be high in the cycle following edge WIDTH+1 and busy SHALL fall at edge WIDTH+2.
REQ-023 start while busy=1 SHALL be ignored (no queuing); input changes on a/b/alu_ctrl while busy SHALL not affect the operation.
REQ-024 start held high continuously SHALL begin a new operation at the edge leaving DONE→IDLE+1 (i.e., sampled again in IDLE), giving back-to-back ops every WIDTH+3 cycles.
REQ-025 Undefined alu_ctrl values SHALL execute via the same decode (no error state) and complete with normal latency; overflow = 0.
REQ-026 result, zero, overflow SHALL change only at edges leading out of IDLE (clear) and during CALC/FIX; stable from done until next accepted start.

Reset
REQ-027 reset=1 SHALL immediately (asynchronously) force state IDLE, busy=0, done=0, result=0, zero=0, overflow=0, carry/index/latched operands to 0.
REQ-028 reset asserted mid-operation SHALL abort it with no done pulse; first start after reset release SHALL run a full fresh operation.

Verification
REQ-029 ADD a=0x7FFFFFFF, b=0x00000001 -> result=0x80000000, overflow=1, zero=0, done exactly WIDTH+1 edges after start edge.
REQ-030 SUB a=0x00000005, b=0x00000005 -> result=0, zero=1, overflow=0; SUB a=0x80000000, b=1 -> result=0x7FFFFFFF, overflow=1.
REQ-031 SLT a=0xFFFFFFFF, b=1 -> result=1; SLT a=0x7FFFFFFF, b=0x80000000 -> result=0 (overflow-corrected), overflow output=0.
REQ-032 NOR a=0, b=0 -> result=0xFFFFFFFF; AND 0xF0F0F0F0,0xFF00FF00 -> 0xF000F000; OR same -> 0xFFF0FFF0.
REQ-033 start pulsed again at cycle 5 of a busy op with different operands -> ignored, first op's result unchanged, single done pulse.
REQ-034 reset asserted at CALC bit 10 -> outputs zero immediately, no done; subsequent ADD 3+4 -> result=7 with normal latency.
